// File: rtl/handshake_constant_arbiter_if.sv
// Handshake bundle between the control requesters, the shared constant
// source and the downstream demux.
interface handshake_constant_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int DATA_WIDTH  = 36
);
    logic [NUM_REQ-1:0]     ctrl_valid;
    logic [NUM_REQ-1:0]     ctrl_ready;
    logic [DATA_WIDTH-1:0]  outs;
    logic [INDEX_WIDTH-1:0] outs_index;
    logic                   outs_valid;
    logic                   outs_ready;

    // Upstream requesters plus downstream consumer (drives the arbiter).
    modport master (
        output ctrl_valid,
        input  ctrl_ready,
        input  outs,
        input  outs_index,
        input  outs_valid,
        output outs_ready
    );

    // The arbiter itself.
    modport slave (
        input  ctrl_valid,
        output ctrl_ready,
        output outs,
        output outs_index,
        output outs_valid,
        input  outs_ready
    );
endinterface

// File: rtl/handshake_constant_arbiter.sv
// Round-robin sharing of one handshake constant among NUM_REQ control
// requesters. The granted token lands in a one-entry output register that
// presents the constant tagged with the requester index.
//
//  state   | meaning
//  --------+--------------------------------------------------
//  S_EMPTY | output register holds no token, any request accepted
//  S_FULL  | token held on outs; replaced only when outs_ready
module handshake_constant_arbiter #(
    parameter int                    NUM_REQ     = 4,
    parameter int                    INDEX_WIDTH = 2,
    parameter int                    DATA_WIDTH  = 36,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = 36'h620FDCD07
) (
    input  logic                         clk,
    input  logic                         rst,
    handshake_constant_arbiter_if.slave  bus
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [INDEX_WIDTH-1:0] r_idx_q;
    logic [INDEX_WIDTH-1:0] r_ptr;

    logic                   w_can_accept;
    logic                   w_any_req;
    logic                   w_found;
    logic [INDEX_WIDTH-1:0] w_grant;
    logic [INDEX_WIDTH-1:0] w_ptr_next;
    logic                   w_xfer_in;
    logic                   w_xfer_out;
    logic [NUM_REQ-1:0]     w_ready;

    // Round-robin scan starting at the priority pointer, wrapping at NUM_REQ.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = (int'(r_ptr) + off) % NUM_REQ;
            if (!w_found && bus.ctrl_valid[k]) begin
                w_found = 1'b1;
                w_grant = INDEX_WIDTH'(k);
            end
        end
    end

    assign w_any_req    = |bus.ctrl_valid;
    assign w_can_accept = (r_state == S_EMPTY) || bus.outs_ready;
    // Reset gates the handshake so no requester sees ready in the reset cycle.
    assign w_xfer_in    = w_any_req && w_can_accept && !rst;
    assign w_xfer_out   = (r_state == S_FULL) && bus.outs_ready;
    assign w_ptr_next   = (int'(w_grant) == NUM_REQ - 1) ? '0
                                                         : INDEX_WIDTH'(int'(w_grant) + 1);

    // Next-state and one-hot ready generation.
    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        if (w_xfer_in) begin
            w_state_next     = S_FULL;
            w_ready[w_grant] = 1'b1;
        end else if (w_xfer_out) begin
            w_state_next = S_EMPTY;
        end
    end

    // State, latched index and pointer; pointer moves only on transfer-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_idx_q <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer_in) begin
                r_idx_q <= w_grant;
                r_ptr   <= w_ptr_next;
            end
        end
    end

    assign bus.ctrl_ready = w_ready;
    assign bus.outs       = CONST_VALUE;
    assign bus.outs_index = r_idx_q;
    assign bus.outs_valid = (r_state == S_FULL);

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Scoreboard bench for handshake_constant_arbiter: accepted indices are
// queued when granted and compared when the output register drains.
`timescale 1ns/1ps
module tb_handshake_constant_arbiter;

    localparam int               NUM_REQ     = 4;
    localparam int               INDEX_WIDTH = 2;
    localparam int               DATA_WIDTH  = 36;
    localparam logic [35:0]      CONST_VALUE = 36'h620FDCD07;

    logic clk = 1'b0;
    logic rst = 1'b1;

    handshake_constant_arbiter_if #(
        .NUM_REQ(NUM_REQ), .INDEX_WIDTH(INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    handshake_constant_arbiter #(
        .NUM_REQ(NUM_REQ), .INDEX_WIDTH(INDEX_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .CONST_VALUE(CONST_VALUE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic       m_full = 1'b0;
    int         m_ptr  = 0;
    int         sb_q[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance model.
    task automatic cycle(input logic [3:0] v, input logic ordy, input logic r);
        logic [3:0] exp_rdy;
        logic       can;
        int         g;
        @(negedge clk);
        bus.ctrl_valid = v;
        bus.outs_ready = ordy;
        rst            = r;
        #1;
        can     = !m_full || ordy;
        g       = -1;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (g < 0 && v[(m_ptr + off) % NUM_REQ]) g = (m_ptr + off) % NUM_REQ;
        end
        exp_rdy = '0;
        if (!r && can && g >= 0) exp_rdy[g] = 1'b1;
        check_val("ctrl_ready", 64'(bus.ctrl_ready), 64'(exp_rdy));
        check_val("outs_valid", 64'(bus.outs_valid), 64'(m_full));
        check_val("outs", 64'(bus.outs), 64'(CONST_VALUE));
        if (m_full) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 64'(0), 64'(1));
            end else begin
                check_val("outs_index", 64'(bus.outs_index), 64'(sb_q[0]));
            end
        end
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end else begin
            if (m_full && ordy && sb_q.size() > 0) void'(sb_q.pop_front());
            if (can && g >= 0) begin
                m_full = 1'b1;
                sb_q.push_back(g);
                m_ptr = (g == NUM_REQ - 1) ? 0 : g + 1;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
        end
    endtask

    initial begin
        bus.ctrl_valid = '0;
        bus.outs_ready = 1'b0;
        rst            = 1'b1;
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);

        // reset state
        cycle(4'b0000, 1'b1, 1'b0);
        check_val("rst_outs_valid", 64'(bus.outs_valid), 64'(0));
        check_val("rst_outs_index", 64'(bus.outs_index), 64'(0));

        // single requester
        cycle(4'b0100, 1'b1, 1'b0);
        check_val("t1_ready", 64'(bus.ctrl_ready), 64'(4'b0100));
        cycle(4'b0000, 1'b1, 1'b0);
        check_val("t1_valid", 64'(bus.outs_valid), 64'(1));
        check_val("t1_index", 64'(bus.outs_index), 64'(2));
        cycle(4'b1111, 1'b1, 1'b0);
        check_val("t1_ptr3", 64'(bus.ctrl_ready), 64'(4'b1000));

        // all four valid: strict rotation, full throughput
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            check_val("t2_grant", 64'(bus.ctrl_ready), 64'(4'b0001 << (i % 4)));
            check_val("t2_valid", 64'(bus.outs_valid), 64'(1));
        end

        // backpressure
        cycle(4'b1111, 1'b1, 1'b0);
        check_val("t3_first", 64'(bus.ctrl_ready), 64'(4'b0001));
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            check_val("t3_stall_rdy", 64'(bus.ctrl_ready), 64'(0));
            check_val("t3_stall_idx", 64'(bus.outs_index), 64'(0));
        end
        cycle(4'b1111, 1'b1, 1'b0);
        check_val("t3_release", 64'(bus.ctrl_ready), 64'(4'b0010));

        // wrap and skip
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        check_val("t4_skip", 64'(bus.ctrl_ready), 64'(4'b0010));
        cycle(4'b1001, 1'b1, 1'b0);
        check_val("t4_wrap", 64'(bus.ctrl_ready), 64'(4'b1000));

        // drain with no new request
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        check_val("t5_valid", 64'(bus.outs_valid), 64'(0));
        check_val("t5_index", 64'(bus.outs_index), 64'(3));
        cycle(4'b1111, 1'b1, 1'b0);
        check_val("t5_ptr", 64'(bus.ctrl_ready), 64'(4'b0001));

        // reset mid-stream
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b1);
        check_val("t6_rst_rdy", 64'(bus.ctrl_ready), 64'(0));
        check_val("t6_pre_idx", 64'(bus.outs_index), 64'(2));
        cycle(4'b1111, 1'b1, 1'b0);
        check_val("t6_post_valid", 64'(bus.outs_valid), 64'(0));
        check_val("t6_first", 64'(bus.ctrl_ready), 64'(4'b0001));

        // random traffic against the model
        for (int i = 0; i < 60; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        end
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        check_val("end_sb_empty", 64'(sb_q.size()), 64'(0));
        check_val("end_valid", 64'(bus.outs_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
